// File: rtl/matrix_pkg.sv
// Constants and helpers shared by the matrix_cal_top pipeline stages.
// Defaults match the row-transform output (source width + 4 bits, 16 lanes).
package matrix_pkg;

  localparam int DEF_DATA_WIDTH = 32'sd12;
  localparam int DEF_N          = 32'sd16;
  localparam int DEF_LANE_BITS  = DEF_N * DEF_DATA_WIDTH;

  // Smallest w with 2**w >= value; loop bound keeps it synthesizable.
  function automatic int clog2(input int value);
    int w;
    w = 32'sd0;
    for (int i = 32'sd0; i < 32'sd31; i++) begin
      if ((32'sd1 << i) < value) begin
        w = i + 32'sd1;
      end else begin
        w = w;
      end
    end
    return w;
  endfunction

  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/matrix_tp_bank.sv
// One N x N element bank: row-wide write port, and a read port that returns
// either row idx (bypass) or column idx (transpose) as an N-lane word.
module matrix_tp_bank
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N,
  parameter int CW         = clog2(N)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [CW-1:0]           wr_row,
  input  logic [N*DATA_WIDTH-1:0] wr_data,
  input  logic [CW-1:0]           rd_idx,
  input  logic                    rd_byp,
  output logic [N*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_r [N][N];

  // Element storage; cleared on reset so out_data reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 32'sd0; r < N; r++) begin
        for (int c = 32'sd0; c < N; c++) begin
          mem_r[r][c] <= '0;
        end
      end
    end else if (wr_en) begin
      for (int c = 32'sd0; c < N; c++) begin
        mem_r[wr_row][c] <= wr_data[lane_lsb(c, DATA_WIDTH) +: DATA_WIDTH];
      end
    end
  end

  // Read mux: lane r is element (idx, r) in bypass, (r, idx) when transposing.
  always_comb begin
    rd_data = '0;
    for (int r = 32'sd0; r < N; r++) begin
      if (rd_byp) begin
        rd_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = mem_r[rd_idx][r];
      end else begin
        rd_data[lane_lsb(r, DATA_WIDTH) +: DATA_WIDTH] = mem_r[r][rd_idx];
      end
    end
  end

endmodule

// File: rtl/matrix_transpose_pp.sv
// Ping-pong transpose buffer between the row and column transform stages:
// N row beats in, N column beats out, two banks so writes overlap reads.
module matrix_transpose_pp
  import matrix_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N          = DEF_N
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_bypass,
  input  logic                    in_vld,
  output logic                    in_rdy,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  output logic                    out_vld,
  input  logic                    out_rdy,
  output logic [N*DATA_WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic [1:0]              occupancy
);

  localparam int            CW      = clog2(N);
  localparam logic [CW-1:0] CNT_MAX = CW'(N - 32'sd1);

  logic [1:0]    full_r;
  logic [1:0]    byp_r;
  logic          wr_bank_r;
  logic          rd_bank_r;
  logic [CW-1:0] wr_cnt_r;
  logic [CW-1:0] rd_cnt_r;

  logic          wr_fire_s;
  logic          rd_fire_s;
  logic          wr_done_s;
  logic          rd_done_s;
  logic [1:0]    full_next_s;
  logic [N*DATA_WIDTH-1:0] bank_data_s [2];

  // All handshake/status outputs come straight from state registers.
  assign in_rdy    = ~full_r[wr_bank_r];
  assign out_vld   = full_r[rd_bank_r];
  assign out_last  = full_r[rd_bank_r] & (rd_cnt_r == CNT_MAX);
  assign occupancy = {1'b0, full_r[0]} + {1'b0, full_r[1]};
  assign out_data  = bank_data_s[rd_bank_r];

  assign wr_fire_s = in_vld & ~full_r[wr_bank_r];
  assign rd_fire_s = out_rdy & full_r[rd_bank_r];
  assign wr_done_s = wr_fire_s & (wr_cnt_r == CNT_MAX);
  assign rd_done_s = rd_fire_s & (rd_cnt_r == CNT_MAX);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    matrix_tp_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .N          (N),
      .CW         (CW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_fire_s && (wr_bank_r == 1'(b))),
      .wr_row  (wr_cnt_r),
      .wr_data (in_data),
      .rd_idx  (rd_cnt_r),
      .rd_byp  (byp_r[b]),
      .rd_data (bank_data_s[b])
    );
  end

  // Completion and release always target different banks, so both may apply.
  always_comb begin
    full_next_s = full_r;
    if (wr_done_s) begin
      full_next_s[wr_bank_r] = 1'b1;
    end else begin
      full_next_s = full_next_s;
    end
    if (rd_done_s) begin
      full_next_s[rd_bank_r] = 1'b0;
    end else begin
      full_next_s = full_next_s;
    end
  end

  // Write/read pointers, row/column counters and per-bank flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_r    <= 2'b00;
      byp_r     <= 2'b00;
      wr_bank_r <= 1'b0;
      rd_bank_r <= 1'b0;
      wr_cnt_r  <= '0;
      rd_cnt_r  <= '0;
    end else begin
      full_r <= full_next_s;
      if (wr_fire_s) begin
        if (wr_cnt_r == '0) begin
          byp_r[wr_bank_r] <= cfg_bypass;
        end
        if (wr_done_s) begin
          wr_cnt_r  <= '0;
          wr_bank_r <= ~wr_bank_r;
        end else begin
          wr_cnt_r <= wr_cnt_r + CW'(1);
        end
      end
      if (rd_fire_s) begin
        if (rd_done_s) begin
          rd_cnt_r  <= '0;
          rd_bank_r <= ~rd_bank_r;
        end else begin
          rd_cnt_r <= rd_cnt_r + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_matrix_transpose_pp.sv
// Scoreboard bench for matrix_transpose_pp with N=4, DATA_WIDTH=12.
module tb_matrix_transpose_pp;

  localparam int DW = 12;
  localparam int NN = 4;
  localparam int W  = NN * DW;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_bypass = 1'b0;
  logic         in_vld = 1'b0;
  logic         in_rdy;
  logic [W-1:0] in_data = '0;
  logic         out_vld;
  logic         out_rdy = 1'b0;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  int last_cnt = 0;
  int blk_id = 0;

  exp_t         exp_q[$];
  logic [W-1:0] model_rows [NN];
  int           model_cnt = 0;
  logic         model_byp = 1'b0;

  matrix_transpose_pp #(.DATA_WIDTH(DW), .N(NN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_bypass (cfg_bypass),
    .in_vld     (in_vld),
    .in_rdy     (in_rdy),
    .in_data    (in_data),
    .out_vld    (out_vld),
    .out_rdy    (out_rdy),
    .out_data   (out_data),
    .out_last   (out_last),
    .occupancy  (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] make_row(input int blk, input int r);
    logic [W-1:0] d;
    for (int c = 0; c < NN; c++) d[c*DW +: DW] = 12'(16*r + c + 256*blk);
    return d;
  endfunction

  function automatic logic [W-1:0] make_col(input int blk, input int c);
    logic [W-1:0] d;
    for (int r = 0; r < NN; r++) d[r*DW +: DW] = 12'(16*r + c + 256*blk);
    return d;
  endfunction

  task automatic model_accept(input logic [W-1:0] d, input logic b);
    exp_t e;
    if (model_cnt == 0) model_byp = b;
    model_rows[model_cnt] = d;
    if (model_cnt == NN - 1) begin
      for (int c = 0; c < NN; c++) begin
        e.data = '0;
        for (int r = 0; r < NN; r++) begin
          if (model_byp) e.data[r*DW +: DW] = model_rows[c][r*DW +: DW];
          else           e.data[r*DW +: DW] = model_rows[r][c*DW +: DW];
        end
        e.last = (c == NN - 1);
        exp_q.push_back(e);
      end
      model_cnt = 0;
    end else begin
      model_cnt++;
    end
  endtask

  // Offer one row; returns at posedge+1 of the accepting edge.
  task automatic drive_row(input logic [W-1:0] d, input logic b);
    int t = 0;
    in_vld = 1'b1; in_data = d; cfg_bypass = b;
    @(negedge clk);
    while (!in_rdy && t < 2000) begin @(negedge clk); t++; end
    if (!in_rdy) begin
      checks++; errors++;
      $display("FAIL in_accept_timeout: in_rdy got 0 required 1 within 2000 cycles");
      in_vld = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_vld = 1'b0;
      model_accept(d, b);
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pending beats got %0d required 0", name, exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Scoreboard: every column handshake is popped and compared.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_vld && out_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_beat: data %h with no expected beat", out_data);
      end else begin
        e = exp_q.pop_front();
        if (out_data !== e.data || out_last !== e.last) begin
          errors++;
          $display("FAIL column_beat: got data %h last %b required data %h last %b",
                   out_data, out_last, e.data, e.last);
        end
        if (out_last) last_cnt++;
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL reset_in_rdy: got %b required 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b required 0", out_vld); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h required 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy: got %0d required 0", occupancy); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_transpose();
    int b = blk_id++;
    out_rdy = 1'b1;
    for (int r = 0; r < NN - 1; r++) drive_row(make_row(b, r), 1'b0);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL tp_vld_early: got %b required 0", out_vld); end
    drive_row(make_row(b, NN - 1), 1'b0);
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL tp_vld_latency: got %b required 1", out_vld); end
    checks++; if (out_data !== make_col(b, 0)) begin errors++; $display("FAIL tp_first_col: got %h required %h", out_data, make_col(b, 0)); end
    wait_drain("transpose");
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL tp_occupancy: got %0d required 0", occupancy); end
  endtask

  task automatic test_bypass();
    int b = blk_id++;
    out_rdy = 1'b1;
    for (int r = 0; r < NN; r++) drive_row(make_row(b, r), (r < 2) ? 1'b1 : 1'b0);
    checks++; if (out_data !== make_row(b, 0)) begin errors++; $display("FAIL byp_first_beat: got %h required %h", out_data, make_row(b, 0)); end
    wait_drain("bypass");
  endtask

  task automatic test_backpressure();
    int b0 = blk_id;
    blk_id += 3;
    out_rdy = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int r = 0; r < NN; r++) drive_row(make_row(b0 + k, r), 1'b0);
    fork
      for (int r = 0; r < NN; r++) drive_row(make_row(b0 + 2, r), 1'b0);
      begin
        repeat (3) @(negedge clk);
        checks++; if (in_rdy !== 1'b0) begin errors++; $display("FAIL bp_in_rdy: got %b required 0", in_rdy); end
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occupancy: got %0d required 2", occupancy); end
        checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL bp_out_vld: got %b required 1", out_vld); end
        checks++; if (out_data !== make_col(b0, 0)) begin errors++; $display("FAIL bp_hold_a: got %h required %h", out_data, make_col(b0, 0)); end
        repeat (3) @(negedge clk);
        checks++; if (out_data !== make_col(b0, 0)) begin errors++; $display("FAIL bp_hold_b: got %h required %h", out_data, make_col(b0, 0)); end
        @(posedge clk); #1;
        out_rdy = 1'b1;
      end
    join
    wait_drain("backpressure");
  endtask

  task automatic test_streaming();
    int b0 = blk_id;
    int in_hs = 0, stalls = 0, out_beats = 0, bubbles = 0;
    blk_id += 4;
    out_rdy = 1'b1;
    fork
      for (int k = 0; k < 4; k++)
        for (int r = 0; r < NN; r++) drive_row(make_row(b0 + k, r), 1'b0);
      for (int cyc = 0; cyc < 40; cyc++) begin
        @(negedge clk);
        if (in_vld && in_rdy) in_hs++;
        if (in_vld && !in_rdy) stalls++;
        if (out_vld) out_beats++;
        else if (out_beats > 0 && out_beats < 16) bubbles++;
      end
    join
    checks++; if (in_hs !== 16) begin errors++; $display("FAIL stream_in_count: got %0d required 16", in_hs); end
    checks++; if (stalls !== 0) begin errors++; $display("FAIL stream_in_stalls: got %0d required 0", stalls); end
    checks++; if (out_beats !== 16) begin errors++; $display("FAIL stream_out_count: got %0d required 16", out_beats); end
    checks++; if (bubbles !== 0) begin errors++; $display("FAIL stream_out_bubbles: got %0d required 0", bubbles); end
    wait_drain("streaming");
  endtask

  task automatic test_random();
    int  b0 = blk_id;
    int  last0 = last_cnt;
    bit  done = 1'b0;
    blk_id += 50;
    fork
      begin
        for (int k = 0; k < 50; k++) begin
          for (int r = 0; r < NN; r++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            drive_row(make_row(b0 + k, r), 1'($urandom_range(0, 1)));
          end
        end
        done = 1'b1;
      end
      while (!done) begin
        out_rdy = 1'($urandom_range(0, 1));
        repeat ($urandom_range(1, 10)) @(posedge clk);
        #1;
      end
    join
    out_rdy = 1'b1;
    wait_drain("random");
    checks++; if (last_cnt - last0 !== 50) begin errors++; $display("FAIL random_last_count: got %0d required 50", last_cnt - last0); end
  endtask

  task automatic test_reset_mid();
    int b = blk_id;
    blk_id += 3;
    out_rdy = 1'b0;
    for (int r = 0; r < NN; r++) drive_row(make_row(b, r), 1'b0);
    for (int r = 0; r < 2; r++) drive_row(make_row(b + 1, r), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (in_rdy !== 1'b1) begin errors++; $display("FAIL mid_rst_in_rdy: got %b required 1", in_rdy); end
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL mid_rst_out_vld: got %b required 0", out_vld); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL mid_rst_out_last: got %b required 0", out_last); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL mid_rst_out_data: got %h required 0", out_data); end
    checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL mid_rst_occupancy: got %0d required 0", occupancy); end
    exp_q.delete();
    model_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    out_rdy = 1'b1;
    for (int r = 0; r < NN; r++) drive_row(make_row(b + 2, r), 1'b0);
    checks++; if (out_data !== make_col(b + 2, 0)) begin errors++; $display("FAIL mid_rst_first_col: got %h required %h", out_data, make_col(b + 2, 0)); end
    wait_drain("reset_mid");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_transpose();
    test_bypass();
    test_backpressure();
    test_streaming();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
